// File: rtl/spu_pkg.sv
// ============================================================================
// spu_pkg : shared widths, types and the MEM/WB lane record for the SPU pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

package spu_pkg;

    localparam int DATA_W       = 128;
    localparam int ADDR_W       = 7;
    localparam int NUM_REGS     = 128;
    localparam int NUM_RD_PORTS = 6;

    typedef logic [DATA_W-1:0] quad_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      mem_to_reg;
        logic      reg_write_enable;
        quad_t     mem_read_data;
        quad_t     result;
        reg_addr_t register_rt;
    } wb_lane_t;

endpackage

`default_nettype wire

// File: rtl/spu_rf_read_port.sv
// ============================================================================
// spu_rf_read_port : one combinational register-file read port with bypass
// Revision: 1.0
// ============================================================================
`default_nettype none

module spu_rf_read_port
    import spu_pkg::*;
(
    input  logic      reset,
    input  reg_addr_t addr_i,
    input  logic      wb_valid1_i,
    input  reg_addr_t wb_rt1_i,
    input  quad_t     wb_data1_i,
    input  logic      wb_valid2_i,
    input  reg_addr_t wb_rt2_i,
    input  quad_t     wb_data2_i,
    input  quad_t     array_data_i,
    output quad_t     data_o
);

    // Lane 2 is younger, so its in-flight value wins over lane 1.
    always_comb begin
        data_o = array_data_i;
        if (reset) begin
            data_o = '0;
        end else if (wb_valid2_i && (addr_i == wb_rt2_i)) begin
            data_o = wb_data2_i;
        end else if (wb_valid1_i && (addr_i == wb_rt1_i)) begin
            data_o = wb_data1_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spu_wb_regfile.sv
// ============================================================================
// spu_wb_regfile : dual-lane writeback select, 128x128 register file, six
//                  bypassed read ports and saturating perf counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module spu_wb_regfile
    import spu_pkg::*;
#(
    parameter int NUM_REGS = spu_pkg::NUM_REGS,
    parameter int DATA_W   = spu_pkg::DATA_W,
    parameter int ADDR_W   = spu_pkg::ADDR_W,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_to_reg1,
    input  logic              reg_write_enable1,
    input  logic [DATA_W-1:0] mem_read_data1,
    input  logic [DATA_W-1:0] result1,
    input  logic [ADDR_W-1:0] register_rt1,
    input  logic              mem_to_reg2,
    input  logic              reg_write_enable2,
    input  logic [DATA_W-1:0] mem_read_data2,
    input  logic [DATA_W-1:0] result2,
    input  logic [ADDR_W-1:0] register_rt2,
    input  logic [ADDR_W-1:0] ra_addr1,
    input  logic [ADDR_W-1:0] rb_addr1,
    input  logic [ADDR_W-1:0] rc_addr1,
    input  logic [ADDR_W-1:0] ra_addr2,
    input  logic [ADDR_W-1:0] rb_addr2,
    input  logic [ADDR_W-1:0] rc_addr2,
    output logic [DATA_W-1:0] ra_data1,
    output logic [DATA_W-1:0] rb_data1,
    output logic [DATA_W-1:0] rc_data1,
    output logic [DATA_W-1:0] ra_data2,
    output logic [DATA_W-1:0] rb_data2,
    output logic [DATA_W-1:0] rc_data2,
    output logic [DATA_W-1:0] wb_data1,
    output logic [DATA_W-1:0] wb_data2,
    output logic              wb_valid1,
    output logic              wb_valid2,
    output logic [CNT_W-1:0]  retire_cnt1,
    output logic [CNT_W-1:0]  retire_cnt2,
    output logic [CNT_W-1:0]  collision_cnt
);

    wb_lane_t          w_lane1;
    wb_lane_t          w_lane2;
    logic              w_collision;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  retire1_q, retire1_d;
    logic [CNT_W-1:0]  retire2_q, retire2_d;
    logic [CNT_W-1:0]  collision_q, collision_d;
    logic [ADDR_W-1:0] w_rd_addr [NUM_RD_PORTS];
    logic [DATA_W-1:0] w_rd_data [NUM_RD_PORTS];

    assign w_lane1 = '{mem_to_reg: mem_to_reg1, reg_write_enable: reg_write_enable1,
                       mem_read_data: mem_read_data1, result: result1,
                       register_rt: register_rt1};
    assign w_lane2 = '{mem_to_reg: mem_to_reg2, reg_write_enable: reg_write_enable2,
                       mem_read_data: mem_read_data2, result: result2,
                       register_rt: register_rt2};

    assign wb_data1  = w_lane1.mem_to_reg ? w_lane1.mem_read_data : w_lane1.result;
    assign wb_data2  = w_lane2.mem_to_reg ? w_lane2.mem_read_data : w_lane2.result;
    assign wb_valid1 = w_lane1.reg_write_enable & ~reset;
    assign wb_valid2 = w_lane2.reg_write_enable & ~reset;

    assign w_collision = wb_valid1 & wb_valid2 &
                         (w_lane1.register_rt == w_lane2.register_rt);

    // Lane 1 is suppressed on a collision so the younger lane-2 value lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wb_valid1 && !w_collision) begin
                regs_q[w_lane1.register_rt] <= wb_data1;
            end
            if (wb_valid2) begin
                regs_q[w_lane2.register_rt] <= wb_data2;
            end
        end
    end

    always_comb begin
        retire1_d   = retire1_q;
        retire2_d   = retire2_q;
        collision_d = collision_q;
        if (wb_valid1 && (retire1_q != '1)) begin
            retire1_d = retire1_q + CNT_W'(1);
        end
        if (wb_valid2 && (retire2_q != '1)) begin
            retire2_d = retire2_q + CNT_W'(1);
        end
        if (w_collision && (collision_q != '1)) begin
            collision_d = collision_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire1_q   <= '0;
            retire2_q   <= '0;
            collision_q <= '0;
        end else begin
            retire1_q   <= retire1_d;
            retire2_q   <= retire2_d;
            collision_q <= collision_d;
        end
    end

    assign retire_cnt1   = retire1_q;
    assign retire_cnt2   = retire2_q;
    assign collision_cnt = collision_q;

    assign w_rd_addr[0] = ra_addr1;
    assign w_rd_addr[1] = rb_addr1;
    assign w_rd_addr[2] = rc_addr1;
    assign w_rd_addr[3] = ra_addr2;
    assign w_rd_addr[4] = rb_addr2;
    assign w_rd_addr[5] = rc_addr2;

    generate
        for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
            spu_rf_read_port u_rd_port (
                .reset        (reset),
                .addr_i       (w_rd_addr[p]),
                .wb_valid1_i  (wb_valid1),
                .wb_rt1_i     (w_lane1.register_rt),
                .wb_data1_i   (wb_data1),
                .wb_valid2_i  (wb_valid2),
                .wb_rt2_i     (w_lane2.register_rt),
                .wb_data2_i   (wb_data2),
                .array_data_i (regs_q[w_rd_addr[p]]),
                .data_o       (w_rd_data[p])
            );
        end
    endgenerate

    assign ra_data1 = w_rd_data[0];
    assign rb_data1 = w_rd_data[1];
    assign rc_data1 = w_rd_data[2];
    assign ra_data2 = w_rd_data[3];
    assign rb_data2 = w_rd_data[4];
    assign rc_data2 = w_rd_data[5];

endmodule

`default_nettype wire

// File: tb/tb_spu_wb_regfile.sv
// ============================================================================
// tb_spu_wb_regfile : scoreboard bench for spu_wb_regfile (32-bit and 2-bit
//                     counter instances share stimulus)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spu_wb_regfile;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_to_reg1, reg_write_enable1, mem_to_reg2, reg_write_enable2;
    logic [127:0] mem_read_data1, result1, mem_read_data2, result2;
    logic [6:0]   register_rt1, register_rt2;
    logic [6:0]   ra_addr1, rb_addr1, rc_addr1, ra_addr2, rb_addr2, rc_addr2;

    logic [127:0] ra_data1, rb_data1, rc_data1, ra_data2, rb_data2, rc_data2;
    logic [127:0] wb_data1, wb_data2;
    logic         wb_valid1, wb_valid2;
    logic [31:0]  retire_cnt1, retire_cnt2, collision_cnt;

    logic [127:0] s_rd [6];
    logic [127:0] s_wb1, s_wb2;
    logic         s_v1, s_v2;
    logic [1:0]   s_ret1, s_ret2, s_col;

    wire  [127:0] rd_act [6];

    int           n_checks = 0;
    int           n_errors = 0;

    logic [127:0] m_regs [128];
    logic [31:0]  m_ret1, m_ret2, m_col;
    logic [1:0]   m_s1, m_s2, m_sc;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    spu_wb_regfile u_dut (
        .clk(clk), .reset(reset),
        .mem_to_reg1(mem_to_reg1), .reg_write_enable1(reg_write_enable1),
        .mem_read_data1(mem_read_data1), .result1(result1), .register_rt1(register_rt1),
        .mem_to_reg2(mem_to_reg2), .reg_write_enable2(reg_write_enable2),
        .mem_read_data2(mem_read_data2), .result2(result2), .register_rt2(register_rt2),
        .ra_addr1(ra_addr1), .rb_addr1(rb_addr1), .rc_addr1(rc_addr1),
        .ra_addr2(ra_addr2), .rb_addr2(rb_addr2), .rc_addr2(rc_addr2),
        .ra_data1(ra_data1), .rb_data1(rb_data1), .rc_data1(rc_data1),
        .ra_data2(ra_data2), .rb_data2(rb_data2), .rc_data2(rc_data2),
        .wb_data1(wb_data1), .wb_data2(wb_data2),
        .wb_valid1(wb_valid1), .wb_valid2(wb_valid2),
        .retire_cnt1(retire_cnt1), .retire_cnt2(retire_cnt2),
        .collision_cnt(collision_cnt)
    );

    spu_wb_regfile #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset),
        .mem_to_reg1(mem_to_reg1), .reg_write_enable1(reg_write_enable1),
        .mem_read_data1(mem_read_data1), .result1(result1), .register_rt1(register_rt1),
        .mem_to_reg2(mem_to_reg2), .reg_write_enable2(reg_write_enable2),
        .mem_read_data2(mem_read_data2), .result2(result2), .register_rt2(register_rt2),
        .ra_addr1(ra_addr1), .rb_addr1(rb_addr1), .rc_addr1(rc_addr1),
        .ra_addr2(ra_addr2), .rb_addr2(rb_addr2), .rc_addr2(rc_addr2),
        .ra_data1(s_rd[0]), .rb_data1(s_rd[1]), .rc_data1(s_rd[2]),
        .ra_data2(s_rd[3]), .rb_data2(s_rd[4]), .rc_data2(s_rd[5]),
        .wb_data1(s_wb1), .wb_data2(s_wb2),
        .wb_valid1(s_v1), .wb_valid2(s_v2),
        .retire_cnt1(s_ret1), .retire_cnt2(s_ret2),
        .collision_cnt(s_col)
    );

    assign rd_act[0] = ra_data1;
    assign rd_act[1] = rb_data1;
    assign rd_act[2] = rc_data1;
    assign rd_act[3] = ra_data2;
    assign rd_act[4] = rb_data2;
    assign rd_act[5] = rc_data2;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; reg_write_enable1 = 1'b0; reg_write_enable2 = 1'b0;
    endtask

    // Drive happens before this call (after a negedge); settle, score, clock, update model.
    task automatic eval();
        logic [6:0]   a [6];
        logic [127:0] w1, w2, e;
        string        names [6] = '{"ra1", "rb1", "rc1", "ra2", "rb2", "rc2"};
        logic         v1, v2, coll;
        #2;
        w1 = mem_to_reg1 ? mem_read_data1 : result1;
        w2 = mem_to_reg2 ? mem_read_data2 : result2;
        v1 = reg_write_enable1 & ~reset;
        v2 = reg_write_enable2 & ~reset;
        a[0] = ra_addr1; a[1] = rb_addr1; a[2] = rc_addr1;
        a[3] = ra_addr2; a[4] = rb_addr2; a[5] = rc_addr2;
        for (int p = 0; p < 6; p++) begin
            if (reset)                        e = '0;
            else if (v2 && a[p] == register_rt2) e = w2;
            else if (v1 && a[p] == register_rt1) e = w1;
            else                              e = m_regs[a[p]];
            exp_q.push_back(e);
        end
        check("wb_data1", wb_data1, w1);
        check("wb_data2", wb_data2, w2);
        check("wb_valid1", 128'(wb_valid1), 128'(v1));
        check("wb_valid2", 128'(wb_valid2), 128'(v2));
        for (int p = 0; p < 6; p++) begin
            e = exp_q.pop_front();
            check(names[p], rd_act[p], e);
            check({"sat_", names[p]}, s_rd[p], e);
        end
        @(posedge clk);
        coll = v1 && v2 && (register_rt1 == register_rt2);
        if (reset) begin
            for (int i = 0; i < 128; i++) m_regs[i] = '0;
            m_ret1 = 0; m_ret2 = 0; m_col = 0; m_s1 = 0; m_s2 = 0; m_sc = 0;
        end else begin
            if (v1 && !coll) m_regs[register_rt1] = w1;
            if (v2)          m_regs[register_rt2] = w2;
            if (v1 && m_ret1 != 32'hFFFF_FFFF) m_ret1++;
            if (v2 && m_ret2 != 32'hFFFF_FFFF) m_ret2++;
            if (coll && m_col != 32'hFFFF_FFFF) m_col++;
            if (v1 && m_s1 != 2'd3) m_s1++;
            if (v2 && m_s2 != 2'd3) m_s2++;
            if (coll && m_sc != 2'd3) m_sc++;
        end
        #1;
        check("retire_cnt1", 128'(retire_cnt1), 128'(m_ret1));
        check("retire_cnt2", 128'(retire_cnt2), 128'(m_ret2));
        check("collision_cnt", 128'(collision_cnt), 128'(m_col));
        check("sat_retire1", 128'(s_ret1), 128'(m_s1));
        check("sat_retire2", 128'(s_ret2), 128'(m_s2));
        check("sat_collision", 128'(s_col), 128'(m_sc));
    endtask

    task automatic set_addrs(input logic [6:0] base);
        ra_addr1 = base;        rb_addr1 = base + 7'd1; rc_addr1 = base + 7'd2;
        ra_addr2 = base + 7'd3; rb_addr2 = base + 7'd4; rc_addr2 = base + 7'd5;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) m_regs[i] = '0;
        m_ret1 = 0; m_ret2 = 0; m_col = 0; m_s1 = 0; m_s2 = 0; m_sc = 0;
        mem_to_reg1 = 0; mem_to_reg2 = 0; mem_read_data1 = '0; mem_read_data2 = '0;
        result1 = '0; result2 = '0; register_rt1 = '0; register_rt2 = '0;
        set_addrs(7'd0);
        idle();

        // Reset, then sweep every address through all six ports.
        @(negedge clk); reset = 1'b1; reg_write_enable1 = 1'b1; eval();
        for (int b = 0; b < 128; b += 6) begin
            @(negedge clk); idle(); set_addrs(7'(b)); eval();
        end
        check("reset_retire1", 128'(retire_cnt1), 128'd0);

        // Lane-1 ALU write with same-cycle bypass, then array read.
        @(negedge clk); idle();
        mem_to_reg1 = 1'b0; result1 = {16{8'hA5}}; register_rt1 = 7'd5;
        reg_write_enable1 = 1'b1; set_addrs(7'd0); ra_addr1 = 7'd5;
        #2; check("t2_bypass", ra_data1, {16{8'hA5}});
        eval();
        @(negedge clk); idle(); ra_addr1 = 7'd5;
        #2; check("t2_array", ra_data1, {16{8'hA5}});
        check("t2_retire1", 128'(retire_cnt1), 128'd1);
        eval();

        // Lane-2 load select.
        @(negedge clk); idle();
        mem_to_reg2 = 1'b1; mem_read_data2 = 128'h1234; result2 = 128'hFFFF;
        register_rt2 = 7'd9; reg_write_enable2 = 1'b1; rb_addr2 = 7'd9;
        eval();
        @(negedge clk); idle(); rb_addr2 = 7'd9;
        #2; check("t3_array", rb_data2, 128'h1234);
        eval();

        // Same-destination collisions; repeated to drive the 2-bit counters to saturation.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); idle();
            mem_to_reg1 = 1'b0; mem_to_reg2 = 1'b0; result1 = 128'd1; result2 = 128'd2;
            register_rt1 = 7'd12; register_rt2 = 7'd12;
            reg_write_enable1 = 1'b1; reg_write_enable2 = 1'b1; rc_addr1 = 7'd12;
            #2; check("t4_bypass", rc_data1, 128'd2);
            eval();
        end
        @(negedge clk); idle(); rc_addr1 = 7'd12;
        #2; check("t4_array", rc_data1, 128'd2);
        check("t4_collision", 128'(collision_cnt), 128'd5);
        check("t4_sat_collision", 128'(s_col), 128'd3);
        eval();

        // Write presented together with reset is dropped.
        @(negedge clk); idle();
        reset = 1'b1; reg_write_enable1 = 1'b1; register_rt1 = 7'd20;
        result1 = 128'hDEAD; ra_addr1 = 7'd20;
        eval();
        @(negedge clk); idle(); ra_addr1 = 7'd20;
        #2; check("t5_reg20", ra_data1, 128'd0);
        check("t5_retire1", 128'(retire_cnt1), 128'd0);
        eval();

        // Randomised traffic over a narrow address window to exercise bypass.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 60) == 0);
            reg_write_enable1 = $urandom_range(0, 1) != 0;
            reg_write_enable2 = $urandom_range(0, 1) != 0;
            mem_to_reg1 = $urandom_range(0, 1) != 0;
            mem_to_reg2 = $urandom_range(0, 1) != 0;
            mem_read_data1 = {$urandom, $urandom, $urandom, $urandom};
            mem_read_data2 = {$urandom, $urandom, $urandom, $urandom};
            result1 = {$urandom, $urandom, $urandom, $urandom};
            result2 = {$urandom, $urandom, $urandom, $urandom};
            register_rt1 = 7'($urandom_range(0, 15));
            register_rt2 = 7'($urandom_range(0, 15));
            ra_addr1 = 7'($urandom_range(0, 15)); rb_addr1 = 7'($urandom_range(0, 15));
            rc_addr1 = 7'($urandom_range(0, 15)); ra_addr2 = 7'($urandom_range(0, 15));
            rb_addr2 = 7'($urandom_range(0, 15)); rc_addr2 = 7'($urandom_range(0, 127));
            eval();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
